// File: rtl/apb_wdog_sequencer.sv
// apb_wdog_sequencer: APB master that configures and kicks the APB watchdog (option: WDOG_READBACK_EN adds a CONTROL readback check)
module apb_wdog_sequencer #(
  parameter int TIMEOUT_CYC = 16,
  parameter bit RELOCK      = 1'b1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cfg_start,
  input  logic [31:0] cfg_load,
  input  logic        cfg_inten,
  input  logic        cfg_resen,
  input  logic        kick_req,
  output logic        kick_ack,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [9:0]  PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  typedef enum logic [2:0] {OP_UNLK, OP_LOAD, OP_CTRL, OP_READ, OP_LOCK, OP_ICLR} op_t;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef WDOG_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam logic [2:0]  CFG_LAST  = 3'(2 + RB + int'(RELOCK));
  localparam logic [2:0]  KICK_LAST = 3'(1 + int'(RELOCK));
  localparam logic [31:0] KEY       = 32'h1ACCE551;
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT_CYC);
  state_t        r_state;
  logic [2:0]    r_step;
  logic          r_kick;
  logic [TW-1:0] r_tcnt;
  logic [31:0]   r_load;
  logic          r_inten;
  logic          r_resen;
  logic          w_start_cfg;
  logic          w_start_kick;
  logic          w_nkick;
  logic [2:0]    w_nstep;
  op_t           w_nop;
  logic [9:0]    w_addr;
  logic [31:0]   w_wdata;
  logic          w_last;
  logic [TW-1:0] w_tinc;
  logic          w_rb_err;
  logic          w_err;
  logic          w_unused;
  assign w_unused     = ^PRDATA;
  assign busy         = r_state != IDLE;
  assign w_start_cfg  = r_state == IDLE && cfg_start;
  assign w_start_kick = r_state == IDLE && !cfg_start && kick_req && done;
  assign w_nkick      = r_state == IDLE ? w_start_kick : r_kick;
  assign w_nstep      = r_state == IDLE ? 3'd0 : r_step + 3'd1;
  assign w_last       = r_step == (r_kick ? KICK_LAST : CFG_LAST);
  assign w_tinc       = r_tcnt == TMAX ? r_tcnt : r_tcnt + 1'b1;
`ifdef WDOG_READBACK_EN
  assign w_rb_err = !r_kick && r_step == 3'd3 && PRDATA[1:0] != {r_resen, r_inten};
`else
  assign w_rb_err = 1'b0;
`endif
  assign w_err = (PREADY && (PSLVERR || w_rb_err)) || (!PREADY && w_tinc == TMAX);
  // Decode the bus operation for the step about to enter SETUP
  always_comb begin
    w_nop   = w_nkick ? (w_nstep == 3'd0 ? OP_UNLK : w_nstep == 3'd1 ? OP_ICLR : OP_LOCK)
                      : (w_nstep == 3'd0 ? OP_UNLK : w_nstep == 3'd1 ? OP_LOAD :
                         w_nstep == 3'd2 ? OP_CTRL : (RB == 1 && w_nstep == 3'd3) ? OP_READ : OP_LOCK);
    w_addr  = (w_nop == OP_LOAD) ? 10'h000 : (w_nop == OP_CTRL || w_nop == OP_READ) ? 10'h002 :
              (w_nop == OP_ICLR) ? 10'h003 : 10'h300;
    w_wdata = (w_nop == OP_UNLK) ? KEY : (w_nop == OP_LOAD) ? r_load :
              (w_nop == OP_CTRL) ? {30'b0, r_resen, r_inten} : (w_nop == OP_ICLR) ? 32'h1 : 32'h0;
  end
  // Sequencer FSM driving the APB master and the status outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= IDLE;
      r_step   <= '0;
      r_kick   <= 1'b0;
      r_tcnt   <= '0;
      r_load   <= '0;
      r_inten  <= 1'b0;
      r_resen  <= 1'b0;
      kick_ack <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
    end else begin
      kick_ack <= 1'b0;
      case (r_state)
        IDLE: if (w_start_cfg || w_start_kick) begin
          if (w_start_cfg) begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            r_load  <= cfg_load;
            r_inten <= cfg_inten;
            r_resen <= cfg_resen;
          end
          r_kick  <= w_start_kick;
          r_step  <= w_nstep;
          r_tcnt  <= '0;
          PSEL    <= 1'b1;
          PADDR   <= w_addr;
          PWRITE  <= w_nop != OP_READ;
          PWDATA  <= w_wdata;
          r_state <= SETUP;
        end
        SETUP: begin
          PENABLE <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS: if (w_err) begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          cfg_err <= 1'b1;
          done    <= r_kick ? 1'b0 : done;
          r_state <= IDLE;
        end else if (PREADY && w_last) begin
          PSEL     <= 1'b0;
          PENABLE  <= 1'b0;
          kick_ack <= r_kick;
          done     <= r_kick ? done : 1'b1;
          r_state  <= IDLE;
        end else if (PREADY) begin
          PENABLE <= 1'b0;
          r_step  <= w_nstep;
          r_tcnt  <= '0;
          PADDR   <= w_addr;
          PWRITE  <= w_nop != OP_READ;
          PWDATA  <= w_wdata;
          r_state <= SETUP;
        end else begin
          r_tcnt <= w_tinc;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_wdog_sequencer.sv
// tb_apb_wdog_sequencer: scoreboard bench with an APB slave model for apb_wdog_sequencer (honours WDOG_READBACK_EN)
module tb_apb_wdog_sequencer;
  localparam logic [31:0] KEY = 32'h1ACCE551;
`ifdef WDOG_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        cfg_start = 1'b0, cfg_inten = 1'b0, cfg_resen = 1'b0, kick_req = 1'b0;
  logic [31:0] cfg_load = '0, PRDATA = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;
  logic        kick_ack, busy, done, cfg_err, PSEL, PENABLE, PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  int n_pass = 0, n_total = 0;
  logic [42:0] exp_q[$];
  logic [9:0]  stall_addr = 10'h3ff, err_addr = 10'h3ff;
  int          stall_n = 0, wcnt = 0;
  bit          stuck = 0, rd_bad = 0;
  logic [31:0] ctrl_reg = '0;
  logic [9:0]  s_a;
  logic        s_w;
  logic [31:0] s_d;
  logic [42:0] e;

  apb_wdog_sequencer dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cfg_start(cfg_start), .cfg_load(cfg_load),
    .cfg_inten(cfg_inten), .cfg_resen(cfg_resen), .kick_req(kick_req), .kick_ack(kick_ack),
    .busy(busy), .done(done), .cfg_err(cfg_err), .PSEL(PSEL), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // APB slave model plus scoreboard: every completing transfer is popped and compared
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      PREADY = 1'b0;
      PSLVERR = 1'b0;
      wcnt = 0;
    end else if (PSEL && !PENABLE) begin
      s_a = PADDR; s_w = PWRITE; s_d = PWDATA;
      wcnt = 0;
      PREADY = 1'b0;
      PSLVERR = 1'b0;
    end else if (PSEL && PENABLE) begin
      n_total++;
      if ({PADDR, PWRITE, PWDATA} !== {s_a, s_w, s_d})
        $display("FAIL stable got %h/%0b/%h want %h/%0b/%h", PADDR, PWRITE, PWDATA, s_a, s_w, s_d);
      else n_pass++;
      if (stuck || (PADDR == stall_addr && wcnt < stall_n)) begin
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        wcnt++;
      end else begin
        PREADY = 1'b1;
        PSLVERR = PWRITE && PADDR == err_addr;
        PRDATA = rd_bad ? 32'h1 : ctrl_reg;
        if (PWRITE && PADDR == 10'h002) ctrl_reg = PWDATA;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL xfer unexpected %h/%0b/%h", PADDR, PWRITE, PWDATA);
        end else begin
          e = exp_q.pop_front();
          if ({PADDR, PWRITE, PWDATA} !== e)
            $display("FAIL xfer got %h/%0b/%h want %h/%0b/%h", PADDR, PWRITE, PWDATA, e[42:33], e[32], e[31:0]);
          else n_pass++;
        end
      end
    end else begin
      PREADY = 1'b0;
      PSLVERR = 1'b0;
    end
  end

  task automatic push(input logic [9:0] a, input logic w, input logic [31:0] d);
    exp_q.push_back({a, w, d});
  endtask

  task automatic push_cfg(input logic [31:0] ld, input logic ie, input logic re);
    push(10'h300, 1'b1, KEY);
    push(10'h000, 1'b1, ld);
    push(10'h002, 1'b1, {30'b0, re, ie});
    if (RB == 1) push(10'h002, 1'b0, 32'h0);
    push(10'h300, 1'b1, 32'h0);
  endtask

  task automatic push_kick();
    push(10'h300, 1'b1, KEY);
    push(10'h003, 1'b1, 32'h1);
    push(10'h300, 1'b1, 32'h0);
  endtask

  task automatic start_cfg(input logic [31:0] ld, input logic ie, input logic re);
    @(negedge PCLK);
    cfg_load = ld; cfg_inten = ie; cfg_resen = re; cfg_start = 1'b1;
    @(negedge PCLK);
    cfg_start = 1'b0;
  endtask

  task automatic pulse_kick();
    @(negedge PCLK);
    kick_req = 1'b1;
    @(negedge PCLK);
    kick_req = 1'b0;
  endtask

  task automatic run_wait(output int nb, output int na);
    nb = 0; na = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      nb++;
      @(negedge PCLK);
      if (kick_ack) na++;
    end
    n_total++;
    if (busy) $display("FAIL wait_idle busy still %0b after 200 cycles, want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge PCLK);
    n_total++;
    if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, busy, done, cfg_err, kick_ack} !== '0)
      $display("FAIL reset_outputs got psel=%0b paddr=%h pwdata=%h busy=%0b done=%0b err=%0b, want all 0",
               PSEL, PADDR, PWDATA, busy, done, cfg_err);
    else n_pass++;
    PRESETn = 1'b1;
  endtask

  task automatic test_config();
    int nb, na;
    push_cfg(32'd50, 1'b1, 1'b1);
    start_cfg(32'd50, 1'b1, 1'b1);
    run_wait(nb, na);
    n_total++;
    if (nb != 8 + 2 * RB) $display("FAIL cfg_cycles got %0d want %0d", nb, 8 + 2 * RB); else n_pass++;
    n_total++;
    if ({done, cfg_err} !== 2'b10) $display("FAIL cfg_status got done=%0b err=%0b want 1/0", done, cfg_err); else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL cfg_xfers got %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_kick();
    int nb, na;
    push_kick();
    pulse_kick();
    run_wait(nb, na);
    repeat (3) begin
      @(negedge PCLK);
      if (kick_ack) na++;
    end
    n_total++;
    if (nb != 6) $display("FAIL kick_cycles got %0d want 6", nb); else n_pass++;
    n_total++;
    if (na != 1) $display("FAIL kick_ack got %0d pulses want 1", na); else n_pass++;
    n_total++;
    if (exp_q.size() != 0 || busy !== 1'b0) $display("FAIL kick_xfers got %0d left busy=%0b want 0/0", exp_q.size(), busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nb, na, i;
    push_kick();
    push_kick();
    @(negedge PCLK);
    kick_req = 1'b1;
    for (i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (kick_ack) break;
    end
    n_total++;
    if (kick_ack !== 1'b1) $display("FAIL b2b_first_ack got %0b want 1", kick_ack); else n_pass++;
    @(negedge PCLK);
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_rearm busy got %0b want 1", busy); else n_pass++;
    kick_req = 1'b0;
    run_wait(nb, na);
    n_total++;
    if (na != 1 || nb != 6) $display("FAIL b2b_second got acks=%0d cycles=%0d want 1/6", na, nb); else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL b2b_xfers got %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_wait_states();
    int nb, na;
    stall_addr = 10'h000; stall_n = 3;
    push_cfg(32'h0000_1234, 1'b0, 1'b1);
    start_cfg(32'h0000_1234, 1'b0, 1'b1);
    run_wait(nb, na);
    stall_addr = 10'h3ff; stall_n = 0;
    n_total++;
    if (nb != 11 + 2 * RB) $display("FAIL wait_cycles got %0d want %0d", nb, 11 + 2 * RB); else n_pass++;
    n_total++;
    if ({done, cfg_err} !== 2'b10 || exp_q.size() != 0)
      $display("FAIL wait_status got done=%0b err=%0b left=%0d want 1/0/0", done, cfg_err, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_slverr();
    int nb, na;
    err_addr = 10'h002;
    push(10'h300, 1'b1, KEY);
    push(10'h000, 1'b1, 32'h77);
    push(10'h002, 1'b1, 32'h2);
    start_cfg(32'h77, 1'b0, 1'b1);
    run_wait(nb, na);
    err_addr = 10'h3ff;
    n_total++;
    if (nb != 6) $display("FAIL err_cycles got %0d want 6", nb); else n_pass++;
    n_total++;
    if ({done, cfg_err} !== 2'b01 || exp_q.size() != 0)
      $display("FAIL err_status got done=%0b err=%0b left=%0d want 0/1/0", done, cfg_err, exp_q.size());
    else n_pass++;
    pulse_kick();
    na = 0; nb = busy ? 1 : 0;
    repeat (6) begin
      @(negedge PCLK);
      if (kick_ack) na++;
      if (busy) nb++;
    end
    n_total++;
    if (na != 0 || nb != 0) $display("FAIL err_kick_blocked got acks=%0d busy=%0d want 0/0", na, nb); else n_pass++;
    push_cfg(32'd50, 1'b1, 1'b1);
    start_cfg(32'd50, 1'b1, 1'b1);
    n_total++;
    if ({busy, done, cfg_err} !== 3'b100) $display("FAIL err_restart got busy=%0b done=%0b err=%0b want 1/0/0", busy, done, cfg_err); else n_pass++;
    run_wait(nb, na);
    n_total++;
    if ({done, cfg_err} !== 2'b10 || exp_q.size() != 0)
      $display("FAIL err_recover got done=%0b err=%0b left=%0d want 1/0/0", done, cfg_err, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int nacc = 0;
    stuck = 1;
    start_cfg(32'd9, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      if (PSEL && PENABLE) nacc++;
      @(negedge PCLK);
    end
    stuck = 0;
    n_total++;
    if (nacc != 16) $display("FAIL timeout_access got %0d cycles want 16", nacc); else n_pass++;
    n_total++;
    if ({busy, PSEL, done, cfg_err} !== 4'b0001 || exp_q.size() != 0)
      $display("FAIL timeout_status got busy=%0b psel=%0b done=%0b err=%0b want 0/0/0/1", busy, PSEL, done, cfg_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_kick();
    int nb, na;
    push_cfg(32'd50, 1'b1, 1'b1);
    start_cfg(32'd50, 1'b1, 1'b1);
    run_wait(nb, na);
    push_kick();
    pulse_kick();
    repeat (2) @(negedge PCLK);
    n_total++;
    if ({PSEL, busy} !== 2'b11) $display("FAIL midkick_active got psel=%0b busy=%0b want 1/1", PSEL, busy); else n_pass++;
    #2 PRESETn = 1'b0;
    #1;
    n_total++;
    if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, busy, done, cfg_err, kick_ack} !== '0)
      $display("FAIL async_reset got psel=%0b pen=%0b paddr=%h pwdata=%h busy=%0b done=%0b want all 0",
               PSEL, PENABLE, PADDR, PWDATA, busy, done);
    else n_pass++;
    exp_q.delete();
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

`ifdef WDOG_READBACK_EN
  task automatic test_readback();
    int nb, na;
    rd_bad = 1;
    push(10'h300, 1'b1, KEY);
    push(10'h000, 1'b1, 32'd50);
    push(10'h002, 1'b1, 32'h3);
    push(10'h002, 1'b0, 32'h0);
    start_cfg(32'd50, 1'b1, 1'b1);
    run_wait(nb, na);
    rd_bad = 0;
    n_total++;
    if ({done, cfg_err} !== 2'b01 || nb != 8 || exp_q.size() != 0)
      $display("FAIL readback got done=%0b err=%0b cycles=%0d want 0/1/8", done, cfg_err, nb);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_config();
    test_kick();
    test_back_to_back();
    test_wait_states();
    test_slverr();
    test_timeout();
    test_reset_mid_kick();
`ifdef WDOG_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
